binarize_adaptive: RTL and testbench

Parametrised luminance binariser for the camera pixel pipeline. Converts a DATA_W-bit Y stream into a 1-bit mask using one of three modes: fixed threshold, band window, or an adaptive threshold from the previous frame's mean luminance plus a signed offset. Sits after the RGB-to-Y stage and feeds erosion/dilation and projection blocks. Frame-sync signals are delayed to stay aligned with the mask.

---
 rtl/binarize_adaptive.sv | 230 +++++++++++++++++++++++
 tb/tb_binarize_adaptive.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/binarize_adaptive.sv
// binarize_adaptive: Y stream -> 1-bit mask (fixed / band / adaptive).
// In: sync+Y, cfg_*; out: delayed sync, post_img_bit, frame_mean, mean_valid.
module binarize_adaptive #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 22
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              per_frame_vsync,
  input  logic              per_frame_href,
  input  logic              per_frame_clken,
  input  logic [DATA_W-1:0] per_img_y,
  input  logic [1:0]        cfg_mode,
  input  logic [DATA_W-1:0] cfg_thresh_lo,
  input  logic [DATA_W-1:0] cfg_thresh_hi,
  input  logic [DATA_W-1:0] cfg_offset,
  input  logic              cfg_invert,
  output logic              post_frame_vsync,
  output logic              post_frame_href,
  output logic              post_frame_clken,
  output logic              post_img_bit,
  output logic [DATA_W-1:0] frame_mean,
  output logic              mean_valid
);

  localparam int SUM_W = DATA_W + CNT_W;
  localparam int BW    = $clog2(SUM_W + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t state, state_nx;

  logic vs_r, vs_ok;
  logic vs_rise, frame_end, pix;

  // vs_ok blocks a false rise when reset releases mid-frame
  assign vs_rise   = per_frame_vsync & ~vs_r & vs_ok;
  assign frame_end = vs_r & ~per_frame_vsync;
  assign pix       = per_frame_vsync & per_frame_href
                   & per_frame_clken;

  logic [1:0]        sh_mode;
  logic [DATA_W-1:0] sh_lo, sh_hi, thr_r;
  logic              sh_inv;

  logic signed [DATA_W+1:0] t_sum;
  logic [DATA_W-1:0]        t_new;

  assign t_sum = $signed({2'b00, frame_mean})
               + $signed({{2{cfg_offset[DATA_W-1]}}, cfg_offset});

  always_comb begin
    t_new = t_sum[DATA_W-1:0];
    if (t_sum[DATA_W+1])
      t_new = '0;
    else if (t_sum[DATA_W])
      t_new = '1;
  end

  // The rise cycle already uses the fresh config
  logic [1:0]        eff_mode;
  logic [DATA_W-1:0] eff_lo, eff_hi, eff_t;
  logic              eff_inv;

  assign eff_mode = vs_rise ? cfg_mode      : sh_mode;
  assign eff_lo   = vs_rise ? cfg_thresh_lo : sh_lo;
  assign eff_hi   = vs_rise ? cfg_thresh_hi : sh_hi;
  assign eff_inv  = vs_rise ? cfg_invert    : sh_inv;
  assign eff_t    = vs_rise ? t_new         : thr_r;

  logic [DATA_W-1:0] lo_d;
  logic              band_d;

  // Adaptive mode reuses the fixed compare with lo = T
  always_comb begin
    lo_d   = eff_lo;
    band_d = 1'b0;
    unique case (1'b1)
      (eff_mode == 2'd1): band_d = 1'b1;
      (eff_mode == 2'd2): lo_d   = eff_t;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_r    <= 1'b0;
      vs_ok   <= 1'b0;
      sh_mode <= '0;
      sh_lo   <= '0;
      sh_hi   <= '0;
      sh_inv  <= 1'b0;
      thr_r   <= '0;
    end else begin
      vs_r  <= per_frame_vsync;
      vs_ok <= vs_ok | ~per_frame_vsync;
      if (vs_rise) begin
        sh_mode <= cfg_mode;
        sh_lo   <= cfg_thresh_lo;
        sh_hi   <= cfg_thresh_hi;
        sh_inv  <= cfg_invert;
        thr_r   <= t_new;
      end
    end
  end

  logic              s1_vs, s1_hs, s1_ck;
  logic              s1_band, s1_inv;
  logic [DATA_W-1:0] s1_y, s1_lo, s1_hi;
  logic              cmp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vs   <= 1'b0;
      s1_hs   <= 1'b0;
      s1_ck   <= 1'b0;
      s1_band <= 1'b0;
      s1_inv  <= 1'b0;
      s1_y    <= '0;
      s1_lo   <= '0;
      s1_hi   <= '0;
    end else begin
      s1_vs   <= per_frame_vsync;
      s1_hs   <= per_frame_href;
      s1_ck   <= per_frame_clken;
      s1_band <= band_d;
      s1_inv  <= eff_inv;
      s1_y    <= per_img_y;
      s1_lo   <= lo_d;
      s1_hi   <= eff_hi;
    end
  end

  // lo >= hi leaves the band empty with no extra term
  assign cmp = s1_band
             ? (s1_y > s1_lo) & (s1_y <= s1_hi)
             : (s1_y > s1_lo);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      post_frame_vsync <= 1'b0;
      post_frame_href  <= 1'b0;
      post_frame_clken <= 1'b0;
      post_img_bit     <= 1'b0;
    end else begin
      post_frame_vsync <= s1_vs;
      post_frame_href  <= s1_hs;
      post_frame_clken <= s1_ck;
      post_img_bit     <= s1_ck & (cmp ^ s1_inv);
    end
  end

  logic             armed;
  logic [SUM_W-1:0] sum;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed <= 1'b0;
      sum   <= '0;
      cnt   <= '0;
    end else if (vs_rise) begin
      armed <= 1'b1;
      sum   <= pix ? SUM_W'(per_img_y) : '0;
      cnt   <= pix ? CNT_W'(1) : '0;
    end else if (frame_end) begin
      armed <= 1'b0;
    end else if (armed & pix & (cnt != CNT_MAX)) begin
      sum <= sum + SUM_W'(per_img_y);
      cnt <= cnt + CNT_W'(1);
    end
  end

  logic [SUM_W-1:0] quo, quo_nx;
  logic [CNT_W-1:0] dvs, rem, rem_nx;
  logic [CNT_W:0]   rem_sh;
  logic [BW-1:0]    bcnt;
  logic             q_bit, last, start;

  assign start  = (state == IDLE) & frame_end & (cnt != '0);
  assign last   = (bcnt == BW'(SUM_W - 1));
  assign rem_sh = {rem, quo[SUM_W-1]};
  assign q_bit  = (rem_sh >= {1'b0, dvs});
  // Low bits of the difference are exact; the carry bit is discarded
  assign rem_nx = q_bit ? rem_sh[CNT_W-1:0] - dvs
                        : rem_sh[CNT_W-1:0];
  assign quo_nx = {quo[SUM_W-2:0], q_bit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = DIV;
      DIV:  if (last)  state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo        <= '0;
      dvs        <= '0;
      rem        <= '0;
      bcnt       <= '0;
      frame_mean <= '0;
    end else if (start) begin
      quo  <= sum;
      dvs  <= cnt;
      rem  <= '0;
      bcnt <= '0;
    end else if (state == DIV) begin
      quo  <= quo_nx;
      rem  <= rem_nx;
      bcnt <= bcnt + BW'(1);
      if (last)
        frame_mean <= quo_nx[DATA_W-1:0];
    end
  end

  assign mean_valid = (state == DONE);

endmodule

// File: tb/tb_binarize_adaptive.sv
// tb_binarize_adaptive: randomized bench with a frame-level model.
// Built with CNT_W=4 so count saturation and short divides are reachable.
module tb_binarize_adaptive;

  localparam int DW = 8;
  localparam int CW = 4;
  localparam int SW = DW + CW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          per_frame_vsync = 1'b0;
  logic          per_frame_href = 1'b0;
  logic          per_frame_clken = 1'b0;
  logic [DW-1:0] per_img_y = '0;
  logic [1:0]    cfg_mode = '0;
  logic [DW-1:0] cfg_thresh_lo = '0;
  logic [DW-1:0] cfg_thresh_hi = '0;
  logic [DW-1:0] cfg_offset = '0;
  logic          cfg_invert = 1'b0;
  logic          post_frame_vsync, post_frame_href;
  logic          post_frame_clken, post_img_bit;
  logic [DW-1:0] frame_mean;
  logic          mean_valid;

  always #5 clk = ~clk;

  binarize_adaptive #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .per_frame_vsync  (per_frame_vsync),
    .per_frame_href   (per_frame_href),
    .per_frame_clken  (per_frame_clken),
    .per_img_y        (per_img_y),
    .cfg_mode         (cfg_mode),
    .cfg_thresh_lo    (cfg_thresh_lo),
    .cfg_thresh_hi    (cfg_thresh_hi),
    .cfg_offset       (cfg_offset),
    .cfg_invert       (cfg_invert),
    .post_frame_vsync (post_frame_vsync),
    .post_frame_href  (post_frame_href),
    .post_frame_clken (post_frame_clken),
    .post_img_bit     (post_img_bit),
    .frame_mean       (frame_mean),
    .mean_valid       (mean_valid)
  );

  int total = 0;
  int passed = 0;

  // Per-cycle history: exp_q[c] is the expected output for input cycle c,
  // obs_q[c] is what the DUT shows in cycle c+1.
  logic [3:0]    exp_q[$];
  logic [3:0]    obs_q[$];
  logic          mv_q[$];
  logic [DW-1:0] fm_q[$];
  logic [DW-1:0] ys[$];
  int            cyc = 0;

  logic          m_pvs, m_seen, m_inv, m_armed, m_pend;
  logic [1:0]    m_mode;
  logic [DW-1:0] m_lo, m_hi, m_t, m_mean, m_pval;
  int            m_done;
  int            m_px[$];

  function automatic logic [3:0] outs();
    return {post_frame_vsync, post_frame_href,
            post_frame_clken, post_img_bit};
  endfunction

  task automatic model_clear();
    m_pvs = 0; m_seen = 0; m_inv = 0; m_armed = 0; m_pend = 0;
    m_mode = 0; m_lo = 0; m_hi = 0; m_t = 0; m_mean = 0; m_pval = 0;
    m_done = 0;
    m_px.delete();
    exp_q.delete(); obs_q.delete(); mv_q.delete(); fm_q.delete();
    cyc = 0;
  endtask

  task automatic tick(input logic vs, input logic hs,
                      input logic ck, input logic [DW-1:0] y);
    int  t, s;
    logic b;
    per_frame_vsync = vs;
    per_frame_href  = hs;
    per_frame_clken = ck;
    per_img_y       = y;
    if (m_pend && cyc >= m_done) begin
      m_mean = m_pval;
      m_pend = 0;
    end
    if (vs && !m_pvs && m_seen) begin
      m_mode = cfg_mode; m_lo = cfg_thresh_lo;
      m_hi = cfg_thresh_hi; m_inv = cfg_invert;
      t = int'(m_mean) + int'($signed(cfg_offset));
      m_t = (t < 0) ? 8'd0 : (t > 255) ? 8'd255 : 8'(t);
      m_px.delete();
      m_armed = 1;
    end
    case (m_mode)
      2'd1:    b = (y > m_lo) && (y <= m_hi);
      2'd2:    b = (y > m_t);
      default: b = (y > m_lo);
    endcase
    exp_q.push_back({vs, hs, ck, ck & (b ^ m_inv)});
    if (m_armed && vs && hs && ck && m_px.size() < 15)
      m_px.push_back(int'(y));
    if (m_pvs && !vs) begin
      if (m_px.size() != 0 && !m_pend) begin
        s = 0;
        foreach (m_px[i]) s += m_px[i];
        m_pval = 8'(s / m_px.size());
        m_pend = 1;
        m_done = cyc + SW + 1;
      end
      m_armed = 0;
    end
    if (!vs) m_seen = 1;
    m_pvs = vs;
    cyc++;
    @(posedge clk);
    #1;
    obs_q.push_back(outs());
    mv_q.push_back(mean_valid);
    fm_q.push_back(frame_mean);
  endtask

  // rise at c0, ys[i] at c0+2+2i (preceded by an href-low gap)
  task automatic frame(input int nrand);
    tick(1'b1, 1'b0, 1'b0, 8'd0);
    foreach (ys[i]) begin
      tick(1'b1, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
      tick(1'b1, 1'b1, 1'b1, ys[i]);
    end
    repeat (nrand)
      tick(1'b1, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 8'($urandom));
  endtask

  task automatic blank(input int n);
    repeat (n) tick(1'b0, 1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (outs() !== 4'b0000)
      $display("FAIL reset_sync got %b want 0000", outs());
    else passed++;
    total++;
    if (mean_valid !== 1'b0)
      $display("FAIL reset_mv got %b want 0", mean_valid);
    else passed++;
    total++;
    if (frame_mean !== 8'd0)
      $display("FAIL reset_mean got %0d want 0", frame_mean);
    else passed++;
    do_reset();
    blank(3);
  endtask

  task automatic test_fixed();
    int s = cyc;
    cfg_mode = 2'd0; cfg_thresh_lo = 8'd16; cfg_invert = 1'b0;
    ys = {8'd16, 8'd17};
    frame(6);
    blank(20);
    cfg_invert = 1'b1;
    frame(6);
    blank(20);
    for (int k = s + 1; k < cyc; k++) begin
      total++;
      if (obs_q[k] !== exp_q[k-1])
        $display("FAIL fixed c%0d got %b want %b",
                 k, obs_q[k], exp_q[k-1]);
      else passed++;
    end
  endtask

  task automatic test_band();
    int s = cyc;
    cfg_mode = 2'd1; cfg_invert = 1'b0;
    cfg_thresh_lo = 8'd50; cfg_thresh_hi = 8'd100;
    ys = {8'd50, 8'd51, 8'd100, 8'd101};
    frame(6);
    blank(20);
    cfg_thresh_lo = 8'd100; cfg_thresh_hi = 8'd50;
    ys = {8'd0, 8'd50, 8'd75, 8'd100, 8'd200, 8'd255};
    frame(6);
    blank(20);
    cfg_mode = 2'd3; cfg_thresh_lo = 8'd128;
    frame(6);
    blank(20);
    for (int k = s + 1; k < cyc; k++) begin
      total++;
      if (obs_q[k] !== exp_q[k-1])
        $display("FAIL band c%0d got %b want %b",
                 k, obs_q[k], exp_q[k-1]);
      else passed++;
    end
  endtask

  task automatic test_adaptive_mean();
    int s = cyc;
    int fe, hit, np;
    cfg_mode = 2'd2; cfg_offset = 8'd0; cfg_invert = 1'b0;
    ys.delete();
    for (int i = 0; i < 16; i++) ys.push_back(8'(i));
    frame(0);
    fe = cyc;
    blank(20);
    hit = -1;
    np = 0;
    for (int k = fe; k < cyc; k++)
      if (mv_q[k]) begin
        np++;
        if (hit < 0) hit = k;
      end
    total++;
    if (hit != fe + SW)
      $display("FAIL mv_latency got %0d want %0d",
               hit - fe + 1, SW + 1);
    else passed++;
    total++;
    if (np != 1)
      $display("FAIL mv_pulses got %0d want 1", np);
    else passed++;
    total++;
    if (fm_q[fe + SW] !== 8'd7)
      $display("FAIL mean_sat got %0d want 7", fm_q[fe + SW]);
    else passed++;
    s = cyc;
    ys = {8'd7, 8'd8, 8'd6, 8'd7};
    frame(0);
    blank(20);
    total++;
    if (obs_q[s + 3][0] !== 1'b0)
      $display("FAIL adapt_y7 got %b want 0", obs_q[s + 3][0]);
    else passed++;
    total++;
    if (obs_q[s + 5][0] !== 1'b1)
      $display("FAIL adapt_y8 got %b want 1", obs_q[s + 5][0]);
    else passed++;
    for (int k = s + 1; k < cyc; k++) begin
      total++;
      if (obs_q[k] !== exp_q[k-1])
        $display("FAIL adapt c%0d got %b want %b",
                 k, obs_q[k], exp_q[k-1]);
      else passed++;
    end
  endtask

  task automatic test_empty_frame();
    int s = cyc;
    int np = 0;
    ys.delete();
    frame(0);
    repeat (3) tick(1'b1, 1'b0, 1'b0, 8'd0);
    blank(30);
    for (int k = s; k < cyc; k++)
      if (mv_q[k]) np++;
    total++;
    if (np != 0)
      $display("FAIL empty_mv got %0d want 0", np);
    else passed++;
    total++;
    if (fm_q[cyc - 1] !== 8'd7)
      $display("FAIL empty_mean got %0d want 7", fm_q[cyc - 1]);
    else passed++;
  endtask

  task automatic test_adaptive_offset();
    int s = cyc;
    cfg_mode = 2'd2; cfg_offset = 8'hF8;
    ys = {8'd0, 8'd1};
    frame(6);
    blank(20);
    total++;
    if (obs_q[s + 3][0] !== 1'b0)
      $display("FAIL sat_y0 got %b want 0", obs_q[s + 3][0]);
    else passed++;
    total++;
    if (obs_q[s + 5][0] !== 1'b1)
      $display("FAIL sat_y1 got %b want 1", obs_q[s + 5][0]);
    else passed++;
    cfg_offset = 8'd100;
    ys = {8'd0, 8'd255, 8'd128};
    frame(6);
    blank(20);
    for (int k = s + 1; k < cyc; k++) begin
      total++;
      if (obs_q[k] !== exp_q[k-1])
        $display("FAIL offset c%0d got %b want %b",
                 k, obs_q[k], exp_q[k-1]);
      else passed++;
    end
  endtask

  task automatic test_mid_cfg();
    int s = cyc;
    int p, c1;
    cfg_mode = 2'd0; cfg_invert = 1'b0;
    cfg_thresh_lo = 8'd60; cfg_thresh_hi = 8'd120;
    ys = {8'd130, 8'd90};
    frame(0);
    cfg_mode = 2'd1;
    p = cyc;
    tick(1'b1, 1'b1, 1'b1, 8'd130);
    tick(1'b1, 1'b0, 1'b0, 8'd0);
    repeat (4) tick(1'b1, 1'($urandom_range(0, 1)),
                    1'b1, 8'($urandom));
    blank(20);
    total++;
    if (obs_q[p + 1][0] !== 1'b1)
      $display("FAIL midcfg_old got %b want 1", obs_q[p + 1][0]);
    else passed++;
    c1 = cyc;
    ys = {8'd130, 8'd90};
    frame(4);
    blank(20);
    total++;
    if (obs_q[c1 + 3][0] !== 1'b0)
      $display("FAIL midcfg_new got %b want 0", obs_q[c1 + 3][0]);
    else passed++;
    for (int k = s + 1; k < cyc; k++) begin
      total++;
      if (obs_q[k] !== exp_q[k-1])
        $display("FAIL midcfg c%0d got %b want %b",
                 k, obs_q[k], exp_q[k-1]);
      else passed++;
    end
  endtask

  task automatic test_reset_div();
    int s, np;
    cfg_mode = 2'd2; cfg_offset = 8'd0; cfg_invert = 1'b0;
    ys = {8'd200, 8'd201, 8'd202, 8'd203, 8'd204};
    frame(0);
    blank(5);
    tick(1'b1, 1'b1, 1'b1, 8'd255);
    tick(1'b1, 1'b1, 1'b1, 8'd255);
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (outs() !== 4'b0000)
      $display("FAIL rstdiv_sync got %b want 0000", outs());
    else passed++;
    total++;
    if (mean_valid !== 1'b0)
      $display("FAIL rstdiv_mv got %b want 0", mean_valid);
    else passed++;
    total++;
    if (frame_mean !== 8'd0)
      $display("FAIL rstdiv_mean got %0d want 0", frame_mean);
    else passed++;
    do_reset();
    repeat (6) tick(1'b1, 1'b1, 1'b1, 8'($urandom));
    blank(40);
    np = 0;
    for (int k = 0; k < cyc; k++)
      if (mv_q[k]) np++;
    total++;
    if (np != 0)
      $display("FAIL rstdiv_nomv got %0d want 0", np);
    else passed++;
    total++;
    if (fm_q[cyc - 1] !== 8'd0)
      $display("FAIL rstdiv_partial got %0d want 0", fm_q[cyc - 1]);
    else passed++;
    s = cyc;
    ys = {8'd0, 8'd1, 8'd5, 8'd255};
    frame(0);
    blank(20);
    total++;
    if (obs_q[s + 3][0] !== 1'b0)
      $display("FAIL post_rst_y0 got %b want 0", obs_q[s + 3][0]);
    else passed++;
    total++;
    if (obs_q[s + 5][0] !== 1'b1)
      $display("FAIL post_rst_y1 got %b want 1", obs_q[s + 5][0]);
    else passed++;
    for (int k = 1; k < cyc; k++) begin
      total++;
      if (obs_q[k] !== exp_q[k-1])
        $display("FAIL rstdiv c%0d got %b want %b",
                 k, obs_q[k], exp_q[k-1]);
      else passed++;
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_fixed();
    test_band();
    test_adaptive_mean();
    test_empty_frame();
    test_adaptive_offset();
    test_mid_cfg();
    test_reset_div();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
